// File: rtl/hex_view_sched.sv
// Round-robin seven-segment debug view: time-shares the four hex digits between
// NUM_SRC 16-bit sources with a dwell timer, manual advance and freeze.
module hex_view_sched #(
  parameter int NUM_SRC = 4,
  parameter int DWELL   = 50_000_000,
  parameter int IDXW    = $clog2(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SRC*16-1:0]   src_data,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic                    adv,
  input  logic                    freeze,
  output logic [6:0]              hex0,
  output logic [6:0]              hex1,
  output logic [6:0]              hex2,
  output logic [6:0]              hex3,
  output logic [IDXW-1:0]         sel_idx,
  output logic                    disp_valid
);

  localparam int CNTW = $clog2(DWELL);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

  state_t            state, next_state;
  logic [15:0]       snapshot;
  logic [15:0]       cur_data;
  logic [CNTW-1:0]   cnt;
  logic              adv_q;
  logic              adv_rise;
  logic              any_valid;
  logic [IDXW-1:0]   pick_idx;
  logic              take_pick;
  logic              load_snap;
  logic              cnt_inc;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b0100111;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign any_valid = |src_valid;
  assign adv_rise  = adv & ~adv_q;

  // Search begins one past the current index, so a lone valid source reselects itself.
  always_comb begin
    int idx;
    logic found;
    pick_idx = sel_idx;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(sel_idx) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && src_valid[idx]) begin
        pick_idx = IDXW'(idx);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    cur_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (IDXW'(i) == sel_idx) cur_data = src_data[16*i +: 16];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    take_pick  = 1'b0;
    load_snap  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          next_state = LOAD;
          take_pick  = 1'b1;
        end
      end
      LOAD: begin
        if (!src_valid[sel_idx]) begin
          next_state = IDLE;
        end else begin
          next_state = SHOW;
          load_snap  = 1'b1;
        end
      end
      SHOW: begin
        // Expiry and a manual edge in the same cycle collapse into one advance.
        if (!any_valid) begin
          next_state = IDLE;
        end else if (!src_valid[sel_idx] || adv_rise || (!freeze && cnt == CNT_LAST)) begin
          next_state = LOAD;
          take_pick  = 1'b1;
        end else if (!freeze) begin
          cnt_inc = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_idx    <= '0;
      snapshot   <= '0;
      cnt        <= '0;
      adv_q      <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      adv_q <= adv;
      if (take_pick) sel_idx <= pick_idx;
      if (load_snap) begin
        snapshot <= cur_data;
        cnt      <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + CNTW'(1);
      end
      // Stays high across a source switch; only entry from IDLE waits for the snapshot.
      disp_valid <= (next_state == SHOW) || (state == SHOW && next_state == LOAD);
    end
  end

  always_comb begin
    hex0 = 7'h7f;
    hex1 = 7'h7f;
    hex2 = 7'h7f;
    hex3 = 7'h7f;
    if (disp_valid) begin
      hex0 = seg7(snapshot[3:0]);
      hex1 = seg7(snapshot[7:4]);
      hex2 = seg7(snapshot[11:8]);
      hex3 = seg7(snapshot[15:12]);
    end
  end

endmodule

// File: tb/tb_hex_view_sched.sv
// Directed bench for hex_view_sched with DWELL=4 and four sources.
module tb_hex_view_sched;

  localparam int NUM_SRC = 4;
  localparam int DWELL   = 4;
  localparam int IDXW    = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_SRC*16-1:0] src_data;
  logic [NUM_SRC-1:0]    src_valid;
  logic                  adv;
  logic                  freeze;
  logic [6:0]            hex0, hex1, hex2, hex3;
  logic [IDXW-1:0]       sel_idx;
  logic                  disp_valid;

  int vecs = 0;
  int errs = 0;

  localparam logic [63:0] DATA4 = {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};

  hex_view_sched #(.NUM_SRC(NUM_SRC), .DWELL(DWELL), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .adv(adv), .freeze(freeze), .hex0(hex0), .hex1(hex1), .hex2(hex2),
    .hex3(hex3), .sel_idx(sel_idx), .disp_valid(disp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [27:0] digits = {hex3, hex2, hex1, hex0};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    src_valid = '0;
    src_data  = DATA4;
    adv       = 1'b0;
    freeze    = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    #1;
    vecs++;
    if (disp_valid !== 1'b0) begin errs++; $display("FAIL reset_disp_valid got %b want 0", disp_valid); end
    vecs++;
    if (sel_idx !== 2'd0) begin errs++; $display("FAIL reset_sel got %0d want 0", sel_idx); end
    vecs++;
    if (digits !== 28'hfffffff) begin errs++; $display("FAIL reset_digits got %h want fffffff", digits); end
    rst = 1'b1;
    step(); step(); step();
    vecs++;
    if (disp_valid !== 1'b0 || sel_idx !== 2'd0) begin
      errs++; $display("FAIL idle_no_src got dv=%b sel=%0d want dv=0 sel=0", disp_valid, sel_idx);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_sel [20];
    for (int i = 0; i < 20; i++) exp_sel[i] = 2'((i / 5 + 1) % 4);
    do_reset();
    src_valid = 4'hF;
    for (int i = 0; i < 20; i++) begin
      step();
      vecs++;
      if (sel_idx !== exp_sel[i]) begin
        errs++; $display("FAIL rot_sel[%0d] got %0d want %0d", i, sel_idx, exp_sel[i]);
      end
      if (i == 0) begin
        vecs++;
        if (disp_valid !== 1'b0) begin errs++; $display("FAIL rot_first_load_dv got %b want 0", disp_valid); end
      end
      if (i == 1 || i == 5) begin
        vecs++;
        if (disp_valid !== 1'b1 || digits !== {7'h19, 7'h12, 7'h02, 7'h78}) begin
          errs++; $display("FAIL rot_src1_digits[%0d] got dv=%b %h want dv=1 %h", i, disp_valid, digits, {7'h19, 7'h12, 7'h02, 7'h78});
        end
      end
      if (i == 6) begin
        vecs++;
        if (digits !== {7'h00, 7'h10, 7'h08, 7'h03}) begin
          errs++; $display("FAIL rot_src2_digits got %h want %h", digits, {7'h00, 7'h10, 7'h08, 7'h03});
        end
      end
    end
  endtask

  task automatic test_skip_single();
    logic [1:0] exp_sel;
    do_reset();
    src_valid = 4'b0101;
    for (int i = 0; i < 15; i++) begin
      step();
      exp_sel = ((i / 5) % 2 == 0) ? 2'd2 : 2'd0;
      vecs++;
      if (sel_idx !== exp_sel) begin
        errs++; $display("FAIL skip_sel[%0d] got %0d want %0d", i, sel_idx, exp_sel);
      end
    end
    do_reset();
    src_valid = 4'b0001;
    step(); step();
    src_data[15:0] = 16'hABCD;
    step(); step(); step();
    vecs++;
    if (sel_idx !== 2'd0 || digits !== {7'h40, 7'h79, 7'h24, 7'h30}) begin
      errs++; $display("FAIL single_old_snapshot got sel=%0d %h want sel=0 %h", sel_idx, digits, {7'h40, 7'h79, 7'h24, 7'h30});
    end
    step();
    vecs++;
    if (sel_idx !== 2'd0 || digits !== {7'h40, 7'h79, 7'h24, 7'h30}) begin
      errs++; $display("FAIL single_reload_cycle got sel=%0d %h want sel=0 %h", sel_idx, digits, {7'h40, 7'h79, 7'h24, 7'h30});
    end
    step();
    vecs++;
    if (digits !== {7'h08, 7'h03, 7'h27, 7'h21}) begin
      errs++; $display("FAIL single_refresh got %h want %h", digits, {7'h08, 7'h03, 7'h27, 7'h21});
    end
  endtask

  task automatic test_freeze_adv();
    do_reset();
    src_valid = 4'hF;
    step(); step();
    freeze = 1'b1;
    for (int i = 0; i < 20; i++) step();
    vecs++;
    if (sel_idx !== 2'd1 || digits !== {7'h19, 7'h12, 7'h02, 7'h78}) begin
      errs++; $display("FAIL freeze_hold got sel=%0d %h want sel=1 %h", sel_idx, digits, {7'h19, 7'h12, 7'h02, 7'h78});
    end
    adv = 1'b1;
    step();
    adv = 1'b0;
    vecs++;
    if (sel_idx !== 2'd2 || digits !== {7'h19, 7'h12, 7'h02, 7'h78}) begin
      errs++; $display("FAIL adv_load got sel=%0d %h want sel=2 old digits", sel_idx, digits);
    end
    step();
    vecs++;
    if (digits !== {7'h00, 7'h10, 7'h08, 7'h03}) begin
      errs++; $display("FAIL adv_digits got %h want %h", digits, {7'h00, 7'h10, 7'h08, 7'h03});
    end
    step(); step(); step(); step(); step();
    vecs++;
    if (sel_idx !== 2'd2) begin errs++; $display("FAIL adv_once_frozen got %0d want 2", sel_idx); end
    adv = 1'b1;
    for (int i = 0; i < 10; i++) step();
    adv = 1'b0;
    vecs++;
    if (sel_idx !== 2'd3) begin errs++; $display("FAIL adv_held got %0d want 3", sel_idx); end
    freeze = 1'b0;
  endtask

  task automatic test_dropout();
    do_reset();
    src_valid = 4'hF;
    step(); step(); step();
    src_valid = 4'b1101;
    step();
    vecs++;
    if (sel_idx !== 2'd2) begin errs++; $display("FAIL drop_sel got %0d want 2", sel_idx); end
    step();
    vecs++;
    if (disp_valid !== 1'b1 || digits !== {7'h00, 7'h10, 7'h08, 7'h03}) begin
      errs++; $display("FAIL drop_digits got dv=%b %h want dv=1 %h", disp_valid, digits, {7'h00, 7'h10, 7'h08, 7'h03});
    end
    src_valid = 4'b0000;
    step();
    vecs++;
    if (disp_valid !== 1'b0 || digits !== 28'hfffffff) begin
      errs++; $display("FAIL all_clear got dv=%b %h want dv=0 fffffff", disp_valid, digits);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    src_valid = 4'hF;
    for (int i = 0; i < 5; i++) step();
    adv = 1'b1;
    step();
    adv = 1'b0;
    vecs++;
    if (sel_idx !== 2'd2) begin errs++; $display("FAIL simul_step got %0d want 2", sel_idx); end
    step(); step();
    vecs++;
    if (sel_idx !== 2'd2) begin errs++; $display("FAIL simul_single got %0d want 2", sel_idx); end
  endtask

  task automatic test_async_reset();
    do_reset();
    src_valid = 4'hF;
    step(); step(); step();
    #2;
    rst = 1'b0;
    #1;
    vecs++;
    if (disp_valid !== 1'b0 || sel_idx !== 2'd0 || digits !== 28'hfffffff) begin
      errs++; $display("FAIL async_rst got dv=%b sel=%0d %h want dv=0 sel=0 fffffff", disp_valid, sel_idx, digits);
    end
    step();
    rst = 1'b1;
    step();
    vecs++;
    if (sel_idx !== 2'd1) begin errs++; $display("FAIL async_resume got %0d want 1", sel_idx); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_skip_single();
    test_freeze_adv();
    test_dropout();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
